// File: rtl/instr_fetch_stage_if.sv
// Bundle of the IF stage's bus signals: the program ROM port, the redirect/halt
// controls coming back from later stages, the IF/ID valid/ready boundary and
// the misalignment fault report.
//   master : the fetch stage (drives ROM address/enables, if_*, fault*)
//   slave  : the surroundings (ROM, decode, branch unit)
interface instr_fetch_stage_if;
  // Program ROM, combinational read, word addressed
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic        rom_read_en;
  logic [31:0] rom_data;
  // Control flow from later stages
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  // IF/ID boundary
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  // Misaligned-redirect report
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output rom_addr, rom_ce, rom_read_en,
    input  rom_data,
    input  redirect_valid, redirect_pc, halt_req, id_ready,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    output fault, fault_pc
  );

  modport slave (
    input  rom_addr, rom_ce, rom_read_en,
    output rom_data,
    output redirect_valid, redirect_pc, halt_req, id_ready,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    input  fault, fault_pc
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage of the MIPS core.
// Holds the PC, presents a word address to a combinational-read program ROM and
// registers the returned word into the IF/ID boundary with a valid/ready
// handshake. Branch/jump redirects replace the PC and kill the pending word;
// a level halt request stops fetching; a misaligned redirect target locks the
// stage in FAULT until reset.
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instr_fetch_stage_if.master
//            rom_addr/rom_ce/rom_read_en/rom_data  - program ROM port
//            redirect_valid/redirect_pc/halt_req    - control flow inputs
//            id_ready/if_valid/if_instr/if_pc/if_pc_plus4 - IF/ID boundary
//            fault/fault_pc                         - sticky misalignment report
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instr_fetch_stage_if.master        bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        rom_ce;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  logic        adv;
  logic        redirect_misaligned;

  // Decode may take the current word, or the boundary is empty: either way a
  // new word can be loaded this cycle.
  assign adv                 = !if_valid || bus.id_ready;
  assign redirect_misaligned = bus.redirect_pc[1:0] != 2'b00;

  // The ROM sees the PC directly, so a held PC keeps the address stable
  // during stalls and halts.
  assign bus.rom_addr    = {2'b00, pc[31:2]};
  assign bus.rom_ce      = rom_ce;
  assign bus.rom_read_en = rom_ce;
  assign bus.if_valid    = if_valid;
  assign bus.if_instr    = if_instr;
  assign bus.if_pc       = if_pc;
  assign bus.if_pc_plus4 = if_pc_plus4;
  assign bus.fault       = fault;
  assign bus.fault_pc    = fault_pc;

  // NOTE: all state here is plain flops updated with non-blocking assignments,
  // so every register reads its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rom_ce      <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      fault       <= 1'b0;
      fault_pc    <= 32'h0;
    end else begin
      case (state)
        // One idle cycle out of reset; redirects are not honoured here.
        BOOT: begin
          if (bus.halt_req) begin
            state <= HALT;
          end else begin
            state  <= RUN;
            rom_ce <= 1'b1;
          end
        end

        RUN: begin
          if (bus.redirect_valid) begin
            // The word at the old PC is dropped even if decode is stalled.
            if_valid <= 1'b0;
            if (redirect_misaligned) begin
              state    <= FAULT;
              rom_ce   <= 1'b0;
              fault    <= 1'b1;
              fault_pc <= bus.redirect_pc;
            end else begin
              pc <= bus.redirect_pc;
            end
          end else if (bus.halt_req) begin
            // Stop fetching; a word consumed this cycle is not replaced.
            state  <= HALT;
            rom_ce <= 1'b0;
            if (bus.id_ready) if_valid <= 1'b0;
          end else if (adv) begin
            if_valid    <= 1'b1;
            if_instr    <= bus.rom_data;
            if_pc       <= pc;
            if_pc_plus4 <= pc + 32'd4;
            pc          <= pc + 32'd4;
          end
        end

        HALT: begin
          if (bus.redirect_valid && redirect_misaligned) begin
            state    <= FAULT;
            if_valid <= 1'b0;
            fault    <= 1'b1;
            fault_pc <= bus.redirect_pc;
          end else begin
            // A redirect while halted only moves the PC; the pending word,
            // if any, drains to decode otherwise.
            if (bus.redirect_valid) begin
              pc       <= bus.redirect_pc;
              if_valid <= 1'b0;
            end else if (bus.id_ready) begin
              if_valid <= 1'b0;
            end
            if (!bus.halt_req) begin
              state  <= RUN;
              rom_ce <= 1'b1;
            end
          end
        end

        // Terminal until reset; outputs were already settled on entry.
        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage. A four-word ROM model answers the
// combinational read; each step advances one rising edge and samples 1 ns
// later, comparing against hand-computed values.
module tb_instr_fetch_stage;

  logic clk;
  logic rst_n;

  instr_fetch_stage_if bus ();

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Program ROM: word0=10, word1=55, word2=244, word3=0, zero elsewhere.
  logic [31:0] rom [4];
  initial begin
    rom[0] = 32'd10;
    rom[1] = 32'd55;
    rom[2] = 32'd244;
    rom[3] = 32'd0;
  end

  always_comb begin
    bus.rom_data = 32'h0;
    if (bus.rom_addr < 32'd4) bus.rom_data = rom[bus.rom_addr[1:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic valid,
                          input logic [31:0] instr, input logic [31:0] pc);
    check({tag, ".if_valid"}, {31'b0, bus.if_valid}, {31'b0, valid});
    if (valid) begin
      check({tag, ".if_instr"},    bus.if_instr,    instr);
      check({tag, ".if_pc"},       bus.if_pc,       pc);
      check({tag, ".if_pc_plus4"}, bus.if_pc_plus4, pc + 32'd4);
    end
  endtask

  task automatic check_ce(input string tag, input logic ce);
    check({tag, ".rom_ce"},      {31'b0, bus.rom_ce},      {31'b0, ce});
    check({tag, ".rom_read_en"}, {31'b0, bus.rom_read_en}, {31'b0, ce});
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;
    bus.id_ready       = 1'b1;
    tick();
    tick();

    // Reset values, then the BOOT cycle.
    check_ce("reset", 1'b0);
    check_if("reset", 1'b0, 32'h0, 32'h0);
    check("reset.if_instr", bus.if_instr, 32'h0);
    check("reset.if_pc", bus.if_pc, 32'h0);
    check("reset.fault", {31'b0, bus.fault}, 32'h0);
    check("reset.fault_pc", bus.fault_pc, 32'h0);
    rst_n = 1'b1;
    check_ce("boot", 1'b0);
    tick();
    check_ce("run0", 1'b1);
    check_if("run0", 1'b0, 32'h0, 32'h0);
    check("run0.rom_addr", bus.rom_addr, 32'd0);

    // Sequential fetch with one-cycle latency.
    tick(); check_if("seq0", 1'b1, 32'd10,  32'd0);
    tick(); check_if("seq1", 1'b1, 32'd55,  32'd4);
    tick(); check_if("seq2", 1'b1, 32'd244, 32'd8);

    // Redirect to 4 while if_pc=8: one bubble, then word1.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd4;
    tick();
    bus.redirect_valid = 1'b0;
    check_if("redir.bubble", 1'b0, 32'h0, 32'h0);
    check("redir.rom_addr", bus.rom_addr, 32'd1);
    tick(); check_if("redir.word", 1'b1, 32'd55, 32'd4);

    // Decode stall for three cycles holds everything.
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_if($sformatf("stall%0d", i), 1'b1, 32'd55, 32'd4);
      check($sformatf("stall%0d.rom_addr", i), bus.rom_addr, 32'd2);
    end
    bus.id_ready = 1'b1;
    tick(); check_if("stall.release", 1'b1, 32'd244, 32'd8);

    // Halt for four cycles: consumed word is not refilled, ROM idle.
    bus.halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ce($sformatf("halt%0d", i), 1'b0);
      check_if($sformatf("halt%0d", i), 1'b0, 32'h0, 32'h0);
      check($sformatf("halt%0d.rom_addr", i), bus.rom_addr, 32'd3);
    end
    bus.halt_req = 1'b0;
    tick();
    check_ce("unhalt", 1'b1);
    check_if("unhalt", 1'b0, 32'h0, 32'h0);
    tick(); check_if("unhalt.next", 1'b1, 32'd0, 32'd12);

    // Halt while decode is stalled: the pending word waits for id_ready.
    bus.halt_req = 1'b1;
    bus.id_ready = 1'b0;
    tick();
    check_ce("halt_pend", 1'b0);
    check_if("halt_pend", 1'b1, 32'd0, 32'd12);
    bus.id_ready = 1'b1;
    tick(); check_if("halt_drain", 1'b0, 32'h0, 32'h0);
    bus.halt_req = 1'b0;
    tick(); check_ce("resume", 1'b1);
    check("resume.rom_addr", bus.rom_addr, 32'd4);

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check_if("wrap.bubble", 1'b0, 32'h0, 32'h0);
    check("wrap.rom_addr", bus.rom_addr, 32'h3FFF_FFFF);
    tick();
    check_if("wrap.top", 1'b1, 32'd0, 32'hFFFF_FFFC);
    check("wrap.plus4", bus.if_pc_plus4, 32'h0);
    tick(); check_if("wrap.zero", 1'b1, 32'd10, 32'd0);

    // Misaligned redirect: sticky fault, redirects ignored afterwards.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0006;
    tick();
    bus.redirect_pc    = 32'h0000_0008;
    check("fault.flag", {31'b0, bus.fault}, 32'd1);
    check("fault.pc", bus.fault_pc, 32'h0000_0006);
    check_ce("fault", 1'b0);
    check_if("fault", 1'b0, 32'h0, 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("fault.hold", {31'b0, bus.fault}, 32'd1);
    check("fault.hold_pc", bus.fault_pc, 32'h0000_0006);
    check_if("fault.hold", 1'b0, 32'h0, 32'h0);

    // Reset pulse clears immediately; redirect during BOOT is ignored.
    rst_n = 1'b0;
    #1;
    check("rst.fault", {31'b0, bus.fault}, 32'd0);
    check("rst.fault_pc", bus.fault_pc, 32'd0);
    check_ce("rst", 1'b0);
    check("rst.if_valid", {31'b0, bus.if_valid}, 32'd0);
    tick();
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd8;
    tick();
    bus.redirect_valid = 1'b0;
    check_ce("reboot", 1'b1);
    check("reboot.rom_addr", bus.rom_addr, 32'd0);
    tick(); check_if("reboot.first", 1'b1, 32'd10, 32'd0);
    tick(); check_if("reboot.second", 1'b1, 32'd55, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
